tmp_seq: RTL and testbench
==========================

Name: tmp_seq

Overview:
- Parametrised successor of the temperature-sensor digital controller.
- Sequences the analog front end: precharge, small-diode, big-diode, high-charge and low-charge phases, driving switch controls PI1/PI2/PII1/PII2/PA-PD and src/snk.
- Times the comparator-terminated charge phases with a counter and averages 2^AVG_LOG samples into an output code.
- Adds programmable phase lengths, timeout detection, single-shot and continuous modes, and a busy/valid handshake.

Parameters:
- CNT_W, 8: width of the charge-phase counters. Timeout limit is 2^CNT_W-1.
- AVG_LOG, 2: log2 of samples averaged per conversion. Range 0..4.
- PRE_CYC, 4: PRECHARGE length in cycles, >=1.
- DIODE_CYC, 8: length of DIODE and of BIGDIODE in cycles, >=1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a conversion; sampled only in IDLE
- cont  in  1  continuous mode: restart after OUTPUT without start
- cmp  in  1  asynchronous analog comparator output
- PI1, PI2, PII1, PII2  out  1 each  diode bias switches
- PA, PB, PC, PD  out  1 each  capacitor path switches
- src, snk  out  1 each  current source/sink enables
- rst  out  1  analog reset
- busy  out  1  high in every state except IDLE
- valid  out  1  one-cycle pulse in OUTPUT
- timeout  out  1  set with valid when the conversion aborted
- code  out  CNT_W+AVG_LOG  accumulated result, held between valid pulses

Behaviour:
- Register timing
  - All outputs are registered and decoded from next-state, so each output matches the current state in the same cycle.
  - cmp passes a 2-flop synchronizer (cmp_s) before use, adding 2 cycles of latency.
- Reset
  - reset=1 at a clk edge forces state to IDLE.
  - Clears counters, accumulator, sample index, code, timeout and valid.
  - All switches, src, snk and busy go to 0; rst goes to 1.
  - A reset arriving mid-conversion discards partial results.
- IDLE
  - rst=1, all switches 0.
  - start=1 or cont=1 -> PRECHARGE.
- PRECHARGE
  - rst=1, PA=PB=1.
  - Lasts PRE_CYC cycles, then -> DIODE.
  - h_cnt and l_cnt clear on entry.
- DIODE
  - PI1=PII1=1, PA=1.
  - Lasts DIODE_CYC cycles, then -> BIGDIODE.
- BIGDIODE
  - PI2=PII2=1, PB=1.
  - Lasts DIODE_CYC cycles, then -> HCHARGE.
- HCHARGE
  - PC=1, src=1.
  - h_cnt increments each cycle with cmp_s=0.
  - First cycle with cmp_s=1 -> LCHARGE; no increment in that cycle.
  - h_cnt reaching 2^CNT_W-1 -> TIMEOUT.
- LCHARGE
  - PD=1, snk=1.
  - l_cnt increments each cycle with cmp_s=1.
  - cmp_s=0 ends the phase. Same timeout rule as HCHARGE.
  - On exit, sample = h_cnt-l_cnt, saturating to 0 when l_cnt>h_cnt, and is added to acc.
  - If sample index < 2^AVG_LOG-1: index++ and -> PRECHARGE. Otherwise -> OUTPUT.
- OUTPUT
  - Lasts 1 cycle. valid=1, code<=acc (acc+last sample), timeout=0.
  - Clears acc and index.
  - cont=1 -> PRECHARGE, else -> IDLE.
- TIMEOUT
  - Lasts 1 cycle. valid=1, timeout=1, code=0.
  - Clears acc and index, then -> IDLE regardless of cont.
- Accumulator width CNT_W+AVG_LOG cannot overflow.
- start while busy is ignored.
- cont deasserted mid-conversion takes effect at the next OUTPUT.
- timeout stays high until the next valid pulse.

Test Plan:
- Reset held 3 cycles, then start=0 -> rst=1, switches/src/snk=0, busy=0, valid=0, code=0; FSM stays in IDLE.
- AVG_LOG=0, start pulse, cmp rises 20 cycles after HCHARGE entry and falls 5 cycles after LCHARGE entry -> h_cnt=22, l_cnt=7, single valid pulse with code=15, timeout=0, busy drops the next cycle. Check phase lengths 4/8/8 and switch patterns per state.
- Defaults, identical cmp model for 4 samples -> exactly one valid pulse after the 4th LCHARGE with code=60; PRECHARGE re-entered 3 times in between.
- cmp stuck 0 -> HCHARGE ends after 255 cycles; TIMEOUT gives valid=1, timeout=1, code=0, then IDLE even with cont=1.
- cmp falls before rising in LCHARGE terms, e.g. h_cnt=3, l_cnt=9 -> sample saturates to 0; with AVG_LOG=0, code=0 and timeout=0.
- cont=1 gives back-to-back conversions with valid every conversion period. reset asserted mid-HCHARGE -> next cycle IDLE, src=0, rst=1, no valid; the following conversion's code is free of stale accumulation.

Source files
------------

// File: rtl/tmp_seq.sv
// Temperature-sensor front-end sequencer: steps the analog switch phases, times the
// comparator-terminated charge phases and averages 2^AVG_LOG samples into one code.
module tmp_seq #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned AVG_LOG   = 2,
    parameter int unsigned PRE_CYC   = 4,
    parameter int unsigned DIODE_CYC = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     cont,
    input  logic                     cmp,
    output logic                     PI1,
    output logic                     PI2,
    output logic                     PII1,
    output logic                     PII2,
    output logic                     PA,
    output logic                     PB,
    output logic                     PC,
    output logic                     PD,
    output logic                     src,
    output logic                     snk,
    output logic                     rst,
    output logic                     busy,
    output logic                     valid,
    output logic                     timeout,
    output logic [CNT_W+AVG_LOG-1:0] code
);

    localparam int unsigned AccW  = CNT_W + AVG_LOG;
    localparam int unsigned PhMax = (PRE_CYC > DIODE_CYC) ? PRE_CYC : DIODE_CYC;
    localparam int unsigned PhW   = $clog2(PhMax + 1);
    localparam int unsigned IdxW  = (AVG_LOG > 0) ? AVG_LOG : 1;

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] CntLast   = CntMax - CNT_W'(1);
    localparam logic [PhW-1:0]   PreLast   = PhW'(PRE_CYC - 1);
    localparam logic [PhW-1:0]   DiodeLast = PhW'(DIODE_CYC - 1);
    localparam logic [IdxW-1:0]  IdxLast   = IdxW'((1 << AVG_LOG) - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StDiode,
        StBigDiode,
        StHCharge,
        StLCharge,
        StOutput,
        StTimeout
    } state_e;

    state_e           state_q, state_d;
    logic [PhW-1:0]   ph_q, ph_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] l_cnt_q, l_cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [AccW-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] sample;
    logic             cmp_meta_q, cmp_s_q;

    // Control bit order: {rst, PI1, PI2, PII1, PII2, PA, PB, PC, PD, src, snk, busy}
    logic [11:0]      ctl_q, ctl_d;
    logic             valid_q, timeout_q;
    logic [AccW-1:0]  code_q;

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q + PhW'(1);
        h_cnt_d = h_cnt_q;
        l_cnt_d = l_cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sample  = '0;

        unique case (state_q)
            StIdle: begin
                if (start || cont) begin
                    state_d = StPre;
                end
            end
            StPre: begin
                h_cnt_d = '0;
                l_cnt_d = '0;
                if (ph_q == PreLast) begin
                    state_d = StDiode;
                end
            end
            StDiode: begin
                if (ph_q == DiodeLast) begin
                    state_d = StBigDiode;
                end
            end
            StBigDiode: begin
                if (ph_q == DiodeLast) begin
                    state_d = StHCharge;
                end
            end
            StHCharge: begin
                if (cmp_s_q) begin
                    state_d = StLCharge;
                end else begin
                    h_cnt_d = h_cnt_q + CNT_W'(1);
                    if (h_cnt_q == CntLast) begin
                        state_d = StTimeout;
                    end
                end
            end
            StLCharge: begin
                if (!cmp_s_q) begin
                    // Sink phase longer than source phase: clamp the sample at zero.
                    sample = (h_cnt_q > l_cnt_q) ? (h_cnt_q - l_cnt_q) : '0;
                    acc_d  = acc_q + AccW'(sample);
                    if (idx_q == IdxLast) begin
                        state_d = StOutput;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StPre;
                    end
                end else begin
                    l_cnt_d = l_cnt_q + CNT_W'(1);
                    if (l_cnt_q == CntLast) begin
                        state_d = StTimeout;
                    end
                end
            end
            StOutput: begin
                acc_d   = '0;
                idx_d   = '0;
                state_d = cont ? StPre : StIdle;
            end
            StTimeout: begin
                acc_d   = '0;
                idx_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Every phase boundary is a state change, so the phase timer restarts there.
        if (state_d != state_q) begin
            ph_d = '0;
        end
    end

    always_comb begin
        ctl_d = '0;
        unique case (state_d)
            StIdle:     ctl_d = 12'b1000_0000_0000;
            StPre:      ctl_d = 12'b1000_0110_0001;
            StDiode:    ctl_d = 12'b0101_0100_0001;
            StBigDiode: ctl_d = 12'b0010_1010_0001;
            StHCharge:  ctl_d = 12'b0000_0001_0101;
            StLCharge:  ctl_d = 12'b0000_0000_1011;
            StOutput:   ctl_d = 12'b0000_0000_0001;
            StTimeout:  ctl_d = 12'b0000_0000_0001;
            default:    ctl_d = 12'b1000_0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ph_q       <= '0;
            h_cnt_q    <= '0;
            l_cnt_q    <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
            ctl_q      <= 12'b1000_0000_0000;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            code_q     <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            h_cnt_q    <= h_cnt_d;
            l_cnt_q    <= l_cnt_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            cmp_meta_q <= cmp;
            cmp_s_q    <= cmp_meta_q;
            ctl_q      <= ctl_d;
            valid_q    <= (state_d == StOutput) || (state_d == StTimeout);
            if (state_d == StOutput) begin
                code_q    <= acc_d;
                timeout_q <= 1'b0;
            end else if (state_d == StTimeout) begin
                code_q    <= '0;
                timeout_q <= 1'b1;
            end
        end
    end

    assign {rst, PI1, PI2, PII1, PII2, PA, PB, PC, PD, src, snk, busy} = ctl_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign code    = code_q;

endmodule

// File: tb/tb_tmp_seq.sv
// Randomised bench for tmp_seq: expected phase timeline and codes come from phase lengths
// and the h-l averaging rule, checked every cycle.
module tb_tmp_seq;

    localparam int unsigned CntW     = 8;
    localparam int unsigned AvgLog   = 2;
    localparam int unsigned PreCyc   = 4;
    localparam int unsigned DiodeCyc = 8;
    localparam int          NSamp    = 1 << AvgLog;
    localparam int          TMax     = (1 << CntW) - 1;

    // {rst, PI1, PI2, PII1, PII2, PA, PB, PC, PD, src, snk, busy, valid}
    localparam logic [12:0] VIdle  = 13'b1000000000000;
    localparam logic [12:0] VPre   = 13'b1000011000010;
    localparam logic [12:0] VDiode = 13'b0101010000010;
    localparam logic [12:0] VBig   = 13'b0010101000010;
    localparam logic [12:0] VHchg  = 13'b0000000101010;
    localparam logic [12:0] VLchg  = 13'b0000000010110;
    localparam logic [12:0] VDone  = 13'b0000000000011;

    logic clk = 1'b0;
    logic reset, start, cont, cmp;
    logic PI1, PI2, PII1, PII2, PA, PB, PC, PD, src, snk, rst, busy, valid, timeout;
    logic [CntW+AvgLog-1:0] code;

    logic [12:0]            ctl_obs;
    logic [CntW+AvgLog-1:0] exp_code;
    logic                   exp_to;
    int                     n_checks = 0;
    int                     n_errors = 0;

    always #5 clk = ~clk;

    assign ctl_obs = {rst, PI1, PI2, PII1, PII2, PA, PB, PC, PD, src, snk, busy, valid};

    tmp_seq #(
        .CNT_W    (CntW),
        .AVG_LOG  (AvgLog),
        .PRE_CYC  (PreCyc),
        .DIODE_CYC(DiodeCyc)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cont   (cont),
        .cmp    (cmp),
        .PI1    (PI1),
        .PI2    (PI2),
        .PII1   (PII1),
        .PII2   (PII2),
        .PA     (PA),
        .PB     (PB),
        .PC     (PC),
        .PD     (PD),
        .src    (src),
        .snk    (snk),
        .rst    (rst),
        .busy   (busy),
        .valid  (valid),
        .timeout(timeout),
        .code   (code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and compare all outputs against the expected phase pattern.
    task automatic cyc(input logic [12:0] exp, input string tag);
        @(posedge clk);
        #1;
        check(tag, 32'(ctl_obs), 32'(exp));
        check({tag, "_res"}, 32'({timeout, code}), 32'({exp_to, exp_code}));
    endtask

    task automatic front_phases();
        for (int i = 0; i < PreCyc; i++) begin
            cyc(VPre, "pre");
            start = 1'b0;
        end
        for (int i = 0; i < DiodeCyc; i++) cyc(VDiode, "diode");
        for (int i = 0; i < DiodeCyc; i++) begin
            cyc(VBig, "bigdiode");
            start = 1'($urandom_range(0, 1));  // ignored while busy
        end
        start = 1'b0;
    endtask

    // r: HCHARGE cycle at which cmp rises (<0 never); f: LCHARGE cycle at which it falls.
    task automatic do_sample(input int r, input int f, output bit to, output int smp);
        int h, l, hlen, llen;
        to  = 1'b0;
        smp = 0;
        front_phases();
        h = (r < 0) ? TMax : r + 2;
        if (h >= TMax) begin
            hlen = TMax;
            to   = 1'b1;
        end else begin
            hlen = h + 1;
        end
        for (int i = 0; i < hlen; i++) begin
            cyc(VHchg, "hcharge");
            if (i == r) cmp = 1'b1;
        end
        if (to) return;
        l = (f < 0) ? TMax : f + 2;
        if (l >= TMax) begin
            llen = TMax;
            to   = 1'b1;
        end else begin
            llen = l + 1;
        end
        for (int i = 0; i < llen; i++) begin
            cyc(VLchg, "lcharge");
            if (i == f) cmp = 1'b0;
        end
        if (to) begin
            cmp = 1'b0;
            return;
        end
        smp = (h > l) ? h - l : 0;
    endtask

    task automatic convert(input int rs[NSamp], input int fs[NSamp], input bit cont_after);
        int sum = 0;
        bit to;
        int smp;
        for (int k = 0; k < NSamp; k++) begin
            do_sample(rs[k], fs[k], to, smp);
            cont = cont_after;
            if (to) begin
                exp_code = '0;
                exp_to   = 1'b1;
                cyc(VDone, "timeout");
                cyc(VIdle, "idle_after_timeout");
                return;
            end
            sum += smp;
        end
        exp_code = (CntW + AvgLog)'(sum);
        exp_to   = 1'b0;
        cyc(VDone, "output");
        if (!cont) cyc(VIdle, "idle_after_output");
    endtask

    initial begin
        int rs[NSamp];
        int fs[NSamp];
        bit to;
        int smp;

        reset    = 1'b1;
        start    = 1'b0;
        cont     = 1'b0;
        cmp      = 1'b0;
        exp_code = '0;
        exp_to   = 1'b0;
        repeat (3) cyc(VIdle, "reset");
        reset = 1'b0;
        cyc(VIdle, "idle");
        cyc(VIdle, "idle");

        // Four identical samples h=22, l=7.
        rs = '{20, 20, 20, 20};
        fs = '{5, 5, 5, 5};
        start = 1'b1;
        convert(rs, fs, 1'b0);

        // Every sample saturates (h=3, l=9).
        rs = '{1, 1, 1, 1};
        fs = '{7, 7, 7, 7};
        start = 1'b1;
        convert(rs, fs, 1'b0);

        // Mixed saturated, equal and positive samples.
        rs = '{1, 30, 2, 10};
        fs = '{7, 3, 0, 10};
        start = 1'b1;
        convert(rs, fs, 1'b0);

        // HCHARGE timeout under continuous mode, then back-to-back conversions.
        cont = 1'b1;
        rs = '{-1, 0, 0, 0};
        fs = '{0, 0, 0, 0};
        convert(rs, fs, 1'b1);
        rs = '{12, 4, 33, 0};
        fs = '{3, 9, 1, 0};
        convert(rs, fs, 1'b1);
        rs = '{40, 40, 40, 40};
        fs = '{0, 1, 2, 3};
        convert(rs, fs, 1'b0);

        // LCHARGE timeout in the second sample.
        rs = '{5, 5, 5, 5};
        fs = '{2, -1, 2, 2};
        start = 1'b1;
        convert(rs, fs, 1'b0);

        // Non-zero code, then reset in the middle of a conversion.
        rs = '{25, 15, 35, 8};
        fs = '{4, 2, 6, 1};
        start = 1'b1;
        convert(rs, fs, 1'b0);
        start = 1'b1;
        do_sample(30, 1, to, smp);
        front_phases();
        for (int i = 0; i < 7; i++) cyc(VHchg, "hcharge_pre_reset");
        reset    = 1'b1;
        exp_code = '0;
        exp_to   = 1'b0;
        cyc(VIdle, "reset_mid_hcharge");
        reset = 1'b0;
        cyc(VIdle, "idle_post_reset");
        rs = '{9, 9, 9, 9};
        fs = '{1, 1, 1, 1};
        start = 1'b1;
        convert(rs, fs, 1'b0);

        // Randomised conversions with random continuation.
        for (int n = 0; n < 8; n++) begin
            bit c;
            for (int k = 0; k < NSamp; k++) begin
                rs[k] = int'($urandom_range(0, 40));
                fs[k] = int'($urandom_range(0, 40));
            end
            c = (n == 7) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!cont) start = 1'b1;
            convert(rs, fs, c);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
